frv_mem_responder: RTL and testbench

//  Target/responder end of the core's req/gnt/recv/ack memory interface. Sits

---
 rtl/frv_mem_responder.sv | 124 ++++++++++++
 tb/tb_frv_mem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/frv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : frv_mem_responder
// Brief    : Responder end of the req/gnt/recv/ack memory interface. It owns a
//            word-addressed SRAM and returns in-order responses from a FIFO.
//            Optional macro FRV_MEM_RSP_STALL_EN adds LFSR-driven stalls.
// Revision : 1.0 - initial release
// ============================================================================
module frv_mem_responder #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          RSP_DEPTH = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_gnt,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata
);

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int          CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    logic [31:0] mem_q   [MEM_WORDS];
    logic [31:0] rdata_q [RSP_DEPTH];
    logic        err_q   [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_err;
    logic             w_accept;
    logic             w_pop;
    logic             w_present;
    logic             w_gnt_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Offset-based range check avoids overflow of MEM_BASE + size.
    assign w_off    = mem_addr - MEM_BASE;
    assign w_idx    = w_off[IDX_W+1:2];
    assign w_err    = (mem_addr[1:0] != 2'b00) || (mem_addr < MEM_BASE) || (w_off >= MEM_BYTES);
    assign w_accept = mem_req && mem_gnt;
    assign w_pop    = w_present && mem_ack;

`ifdef FRV_MEM_RSP_STALL_EN
    logic [15:0] lfsr_q;
    logic        shown_q;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            lfsr_q  <= LFSR_SEED;
            shown_q <= 1'b0;
        end else begin
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            shown_q <= w_present && !mem_ack;
        end
    end

    // Once a response is visible it stays visible until acked.
    assign w_present = (cnt_q != '0) && (shown_q || !lfsr_q[1]);
    assign w_gnt_ok  = !lfsr_q[0];
`else
    assign w_present = (cnt_q != '0);
    assign w_gnt_ok  = 1'b1;
`endif

    assign mem_gnt   = !g_reset && (cnt_q < CNT_W'(RSP_DEPTH)) && w_gnt_ok;
    assign mem_recv  = w_present;
    assign mem_rdata = w_present ? rdata_q[rd_ptr_q] : 32'h0;
    assign mem_error = w_present && err_q[rd_ptr_q];

    always_ff @(posedge g_clk) begin
        if (w_accept && mem_wen && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_strb[b]) begin
                    mem_q[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (w_accept) begin
            rdata_q[wr_ptr_q] <= (mem_wen || w_err) ? 32'h0 : mem_q[w_idx];
            err_q[wr_ptr_q]   <= w_err;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_accept) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({w_accept, w_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_frv_mem_responder
// Brief    : Directed self-checking bench for frv_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frv_mem_responder;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    frv_mem_responder dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_strb  (mem_strb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_recv  (mem_recv),
        .mem_ack   (mem_ack),
        .mem_error (mem_error),
        .mem_rdata (mem_rdata)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Single isolated transaction: accept, check response next cycle, ack it.
    task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input logic exp_err);
        mem_req   = 1'b1;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_strb  = strb;
        chk({tag, "_gnt"}, 32'(mem_gnt), 32'd1);
        tick();
        mem_req   = 1'b0;
        mem_wdata = 32'hFFFF_FFFF;
        chk({tag, "_recv"}, 32'(mem_recv), 32'd1);
        chk({tag, "_rdata"}, mem_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(mem_error), 32'(exp_err));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_idle"}, 32'(mem_recv), 32'd0);
    endtask

    logic [31:0] vals [4];
    int          grants;

    initial begin
        g_reset   = 1'b1;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_strb  = 4'h0;
        mem_wdata = 32'h0;
        mem_addr  = 32'h0;
        mem_ack   = 1'b0;
        vals[0] = 32'hA0A0_0001; vals[1] = 32'hB1B1_0002;
        vals[2] = 32'hC2C2_0003; vals[3] = 32'hD3D3_0004;

        tick();
        tick();
        chk("rst_gnt",   32'(mem_gnt), 32'd0);
        chk("rst_recv",  32'(mem_recv), 32'd0);
        chk("rst_err",   32'(mem_error), 32'd0);
        chk("rst_rdata", mem_rdata, 32'h0);
        g_reset = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(mem_gnt), 32'd1);

        // Full-word write then read back
        xact("t1_wr", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        xact("t1_rd", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte strobe merge and zero-strobe no-op
        xact("t2_wr0", 1'b1, 32'h8000_0014, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
        xact("t2_wr1", 1'b1, 32'h8000_0014, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
        xact("t2_rd",  1'b0, 32'h8000_0014, 32'h0, 4'h0, 32'h1122_33AA, 1'b0);
        xact("t2_wr2", 1'b1, 32'h8000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
        xact("t2_rd2", 1'b0, 32'h8000_0014, 32'h0, 4'h0, 32'h1122_33AA, 1'b0);

        // Error cases and range boundaries
        xact("t3_mis",  1'b0, 32'h8000_0002, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("t3_low",  1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("t3_high", 1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
        xact("t3_miswr", 1'b1, 32'h8000_0012, 32'h0000_0000, 4'hF, 32'h0, 1'b1);
        xact("t3_keep", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        xact("t3_lastwr", 1'b1, 32'h8000_0FFC, 32'h5A5A_A5A5, 4'hF, 32'h0, 1'b0);
        xact("t3_lastrd", 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'h5A5A_A5A5, 1'b0);

        // Backpressure: only RSP_DEPTH grants without ack
        grants   = 0;
        mem_req  = 1'b1;
        mem_wen  = 1'b0;
        mem_addr = 32'h8000_0010;
        for (int i = 0; i < 4; i++) begin
            if (mem_gnt) grants++;
            tick();
        end
        chk("t4_grants", 32'(grants), 32'd2);
        chk("t4_full_gnt", 32'(mem_gnt), 32'd0);
        chk("t4_head", mem_rdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        chk("t4_ack_gnt", 32'(mem_gnt), 32'd0);
        tick();
        mem_ack = 1'b0;
        chk("t4_freed_gnt", 32'(mem_gnt), 32'd1);
        mem_req = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t4_drained", 32'(mem_recv), 32'd0);

        // Streaming reads with ack tied high
        for (int i = 0; i < 4; i++) begin
            xact($sformatf("t5_wr%0d", i), 1'b1, 32'h8000_0020 + 32'(4 * i), vals[i], 4'hF, 32'h0, 1'b0);
        end
        mem_ack = 1'b1;
        mem_req = 1'b1;
        mem_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_addr = 32'h8000_0020 + 32'(4 * i);
            chk($sformatf("t5_gnt%0d", i), 32'(mem_gnt), 32'd1);
            tick();
            chk($sformatf("t5_recv%0d", i), 32'(mem_recv), 32'd1);
            chk($sformatf("t5_rd%0d", i), mem_rdata, vals[i]);
        end
        mem_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        chk("t5_done", 32'(mem_recv), 32'd0);

        // Reset with two outstanding responses
        mem_req  = 1'b1;
        mem_addr = 32'h8000_0010;
        tick();
        mem_addr = 32'h8000_0014;
        tick();
        mem_wen   = 1'b1;
        mem_wdata = 32'h0BAD_0BAD;
        mem_strb  = 4'hF;
        mem_addr  = 32'h8000_0010;
        g_reset   = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(mem_gnt), 32'd0);
        tick();
        g_reset = 1'b0;
        mem_req = 1'b0;
        mem_wen = 1'b0;
        #1;
        chk("t6_recv", 32'(mem_recv), 32'd0);
        chk("t6_gnt", 32'(mem_gnt), 32'd1);
        xact("t6_keep", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
